// File: rtl/divider_iter_pkg.sv
// Shared defines, state encoding and helpers for the iterative divider.
// Holds bus/funct widths, DIV/DIVU codes, state codes and the iteration count.
`ifndef DIVIDER_ITER_DEFS
`define DIVIDER_ITER_DEFS
`define DATA_BUS        31:0
`define DOUBLE_DATA_BUS 63:0
`define FUNCT_BUS       5:0
`define FUNCT_DIV       6'b011010
`define FUNCT_DIVU      6'b011011
`define DIV_IDLE        2'b00
`define DIV_ZERO        2'b01
`define DIV_RUN         2'b10
`define DIV_DONE        2'b11
`define DIV_ITER        32
`endif

package divider_iter_pkg;

  localparam logic [5:0] FUNCT_DIV  = `FUNCT_DIV;
  localparam logic [5:0] FUNCT_DIVU = `FUNCT_DIVU;

  typedef enum logic [1:0] {
    S_IDLE = `DIV_IDLE,
    S_ZERO = `DIV_ZERO,
    S_RUN  = `DIV_RUN,
    S_DONE = `DIV_DONE
  } div_state_e;

  // Magnitude of an operand: only negated when signed and negative.
  function automatic logic [31:0] div_mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/divider_iter_if.sv
// EX-stage <-> divider handshake bundle.
// master = EX (drives request/operands), slave = divider (drives status/result).
interface divider_iter_if;
  logic [`FUNCT_BUS]       funct;
  logic                    div_en;
  logic                    annul;
  logic [`DATA_BUS]        operand_1;
  logic [`DATA_BUS]        operand_2;
  logic                    busy;
  logic                    done;
  logic [`DOUBLE_DATA_BUS] result_div;

  modport master (
    output funct, div_en, annul, operand_1, operand_2,
    input  busy, done, result_div
  );

  modport slave (
    input  funct, div_en, annul, operand_1, operand_2,
    output busy, done, result_div
  );
endinterface

// File: rtl/divider_iter_div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, select.
// Ports: rem_i/rem_o partial remainder, dvd_bit_i next MSB, dvs_i divisor, q_o quotient bit.
module div_restore_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         dvd_bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // Partial remainder stays below the divisor, so the shifted
  // value fits in W+1 bits and diff's MSB is a valid sign.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {2'b00, dvs_i};
    q_o     = ~diff[W+1];
    rem_o   = q_o ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring DIV/DIVU unit; 32 steps, result {rem, quo}.
// Ports: clk, rst (async high), bus (slave). Option macro: DIV_EARLY_OUT_EN.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         rst,
  divider_iter_if.slave bus
);

  div_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;

  logic [DATA_WIDTH:0]     step_rem;
  logic                    step_q;
  logic                    is_div;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [DATA_WIDTH-1:0]   quo_n, rem_n;
  logic [DATA_WIDTH-1:0]   quo_f, rem_f;

  div_restore_step #(
    .W(DATA_WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DATA_WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;

    // Unknown funct codes fall back to unsigned.
    is_div = (bus.funct == `FUNCT_DIV);
    a_mag  = div_mag(bus.operand_1, is_div);
    b_mag  = div_mag(bus.operand_2, is_div);

    // dvd_q doubles as the quotient register as bits shift out.
    quo_n = {dvd_q[DATA_WIDTH-2:0], step_q};
    rem_n = step_rem[DATA_WIDTH-1:0];
    quo_f = neg_quo_q ? -quo_n : quo_n;
    rem_f = neg_rem_q ? -rem_n : rem_n;

    unique case (state_q)
      S_IDLE: begin
        if (bus.div_en) begin
          neg_quo_d = is_div &
                      (bus.operand_1[DATA_WIDTH-1] ^
                       bus.operand_2[DATA_WIDTH-1]);
          neg_rem_d = is_div & bus.operand_1[DATA_WIDTH-1];
          dvs_d     = b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.operand_2 == '0) begin
            // Raw dividend is parked here for the zero result.
            state_d = S_ZERO;
            dvd_d   = bus.operand_1;
            busy_d  = 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = {bus.operand_1, {DATA_WIDTH{1'b0}}};
          end
`endif
          else begin
            state_d = S_RUN;
            dvd_d   = a_mag;
            busy_d  = 1'b1;
          end
        end
      end
      S_ZERO: begin
        state_d  = S_DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = {dvd_q, {DATA_WIDTH{1'b1}}};
      end
      S_RUN: begin
        rem_d = step_rem;
        dvd_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(`DIV_ITER - 1)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = {rem_f, quo_f};
        end
      end
      S_DONE: begin
        if (!bus.div_en) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle start.
    if (bus.annul) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_div = result_q;

endmodule
